ymz_pcm_rom_sequencer: RTL and testbench

- Sequences YMZ280B sample-ROM byte reads onto the three 4 MB SDRAM PCM bank ports (PCM, PCM1, PCM2) in the bakraid sound subsystem.
- Sits between the YMZ280B io_rom_* interface and the SDRAM slot ports.
- Registers each request, decodes the bank, holds a stable CS/address until OK, and returns one byte with a single-cycle valid.
- Provides a one-entry last-byte cache, an out-of-range fill path, a request timeout, and sticky error flags.

---
 rtl/ymz_pcm_rom_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_ymz_pcm_rom_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ymz_pcm_rom_sequencer.sv
// ymz_pcm_rom_sequencer
// Sequences YMZ280B sample-ROM byte reads onto the three 4 MB SDRAM PCM bank
// ports (PCM, PCM1, PCM2). Each accepted request is registered and decoded on
// addr[23:22]. It then takes one of three paths:
//   - a one-entry last-byte cache hit,
//   - an out-of-range fill (bank code 2'b11),
//   - an SDRAM request with a stable CS/address held until OK or timeout.
// One byte is returned with a single-cycle ymz_valid.
//
// Ports
//   CLK96, RESET96            96 MHz clock, asynchronous active-high reset
//   flush                     invalidate the cache (ROM reload)
//   ymz_rd, ymz_addr          read strobe + 24-bit byte address
//   ymz_dout, ymz_valid       returned byte + one-cycle valid
//   ymz_wait                  request in flight (raised combinationally on accept)
//   pcm*_cs, pcm*_addr        registered bank chip select / address
//   pcm*_ok, pcm*_dout        per-bank SDRAM data-ready and data
//   err_timeout, err_overrun  sticky error flags, cleared by err_clr
module ymz_pcm_rom_sequencer #(
  parameter int unsigned BANK_AW   = 22,
  parameter int unsigned TIMEOUT   = 1023,
  parameter logic [7:0]  FILL_BYTE = 8'h00
) (
  input  logic               CLK96,
  input  logic               RESET96,
  input  logic               flush,
  input  logic               ymz_rd,
  input  logic [23:0]        ymz_addr,
  output logic [7:0]         ymz_dout,
  output logic               ymz_valid,
  output logic               ymz_wait,
  output logic               pcm_cs,
  output logic               pcm1_cs,
  output logic               pcm2_cs,
  output logic [BANK_AW-1:0] pcm_addr,
  output logic [BANK_AW-1:0] pcm1_addr,
  output logic [BANK_AW-1:0] pcm2_addr,
  input  logic               pcm_ok,
  input  logic               pcm1_ok,
  input  logic               pcm2_ok,
  input  logic [7:0]         pcm_dout,
  input  logic [7:0]         pcm1_dout,
  input  logic [7:0]         pcm2_dout,
  output logic               err_timeout,
  output logic               err_overrun,
  input  logic               err_clr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIT,
    S_FILL,
    S_REQ,
    S_DONE,
    S_TOUT
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [1:0]  bank;
  logic [15:0] cnt;
  logic        req_flushed;   // a flush arrived while this request was in flight
  logic [23:0] req_addr;
  logic [7:0]  data_q;

  logic        cache_valid;
  logic [23:0] cache_addr;
  logic [7:0]  cache_data;

  logic        busy;
  logic        accept;
  logic        hit;
  logic        sel_ok;
  logic [7:0]  sel_dout;

  // The valid cycle after DONE/TOUT is spent in IDLE, so it also counts as busy.
  // A strobe coinciding with ymz_valid is therefore dropped.
  assign busy     = (state != S_IDLE) || ymz_valid;
  assign accept   = ymz_rd && !busy;
  assign ymz_wait = busy || ymz_rd;
  // A flush in the same cycle as a matching strobe forces a miss.
  assign hit      = cache_valid && !flush && (cache_addr == ymz_addr);

  // Only the bank captured at accept time is honoured; the other OKs are ignored.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    sel_ok   = 1'b0;
    sel_dout = 8'h00;
    case (bank)
      2'd0: begin sel_ok = pcm_ok;  sel_dout = pcm_dout;  end
      2'd1: begin sel_ok = pcm1_ok; sel_dout = pcm1_dout; end
      2'd2: begin sel_ok = pcm2_ok; sel_dout = pcm2_dout; end
      default: begin sel_ok = 1'b0; sel_dout = 8'h00; end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      state       <= S_IDLE;
      bank        <= 2'd0;
      cnt         <= '0;
      req_flushed <= 1'b0;
      req_addr    <= '0;
      data_q      <= '0;
      // NOTE: the cache is a handful of flops, not a RAM, so it is reset
      // outright; reset must leave it invalid anyway.
      cache_valid <= 1'b0;
      cache_addr  <= '0;
      cache_data  <= '0;
      ymz_dout    <= '0;
      ymz_valid   <= 1'b0;
      pcm_cs      <= 1'b0;
      pcm1_cs     <= 1'b0;
      pcm2_cs     <= 1'b0;
      pcm_addr    <= '0;
      pcm1_addr   <= '0;
      pcm2_addr   <= '0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      ymz_valid <= 1'b0;

      if (flush) cache_valid <= 1'b0;

      // err_clr wins over a flag being set in the same cycle.
      if (err_clr) begin
        err_timeout <= 1'b0;
        err_overrun <= 1'b0;
      end else begin
        if (ymz_rd && busy) err_overrun <= 1'b1;
        if (state == S_REQ && !sel_ok && cnt == CNT_LAST) err_timeout <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            req_addr <= ymz_addr;
            if (hit) begin
              ymz_dout  <= cache_data;
              ymz_valid <= 1'b1;
              state     <= S_HIT;
            end else if (ymz_addr[23:22] == 2'b11) begin
              ymz_dout  <= FILL_BYTE;
              ymz_valid <= 1'b1;
              state     <= S_FILL;
            end else begin
              bank        <= ymz_addr[23:22];
              cnt         <= '0;
              req_flushed <= 1'b0;
              case (ymz_addr[23:22])
                2'd0: begin pcm_cs  <= 1'b1; pcm_addr  <= ymz_addr[BANK_AW-1:0]; end
                2'd1: begin pcm1_cs <= 1'b1; pcm1_addr <= ymz_addr[BANK_AW-1:0]; end
                default: begin pcm2_cs <= 1'b1; pcm2_addr <= ymz_addr[BANK_AW-1:0]; end
              endcase
              state <= S_REQ;
            end
          end
        end

        S_HIT, S_FILL: state <= S_IDLE;

        S_REQ: begin
          if (sel_ok) begin
            pcm_cs  <= 1'b0;
            pcm1_cs <= 1'b0;
            pcm2_cs <= 1'b0;
            data_q  <= sel_dout;
            // A flush seen at any point during the request keeps this byte out
            // of the cache; it is still returned to the YMZ.
            if (!flush && !req_flushed) begin
              cache_valid <= 1'b1;
              cache_addr  <= req_addr;
              cache_data  <= sel_dout;
            end
            state <= S_DONE;
          end else if (cnt == CNT_LAST) begin
            pcm_cs  <= 1'b0;
            pcm1_cs <= 1'b0;
            pcm2_cs <= 1'b0;
            state   <= S_TOUT;
          end else begin
            cnt <= cnt + 16'd1;
            if (flush) req_flushed <= 1'b1;
          end
        end

        S_DONE: begin
          ymz_dout  <= data_q;
          ymz_valid <= 1'b1;
          state     <= S_IDLE;
        end

        S_TOUT: begin
          ymz_dout  <= FILL_BYTE;
          ymz_valid <= 1'b1;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ymz_pcm_rom_sequencer.sv
// Directed bench for ymz_pcm_rom_sequencer (TIMEOUT overridden to 16).
module tb_ymz_pcm_rom_sequencer;

  localparam int BANK_AW = 22;

  logic               CLK96 = 1'b0;
  logic               RESET96;
  logic               flush;
  logic               ymz_rd;
  logic [23:0]        ymz_addr;
  logic [7:0]         ymz_dout;
  logic               ymz_valid;
  logic               ymz_wait;
  logic               pcm_cs, pcm1_cs, pcm2_cs;
  logic [BANK_AW-1:0] pcm_addr, pcm1_addr, pcm2_addr;
  logic               pcm_ok, pcm1_ok, pcm2_ok;
  logic [7:0]         pcm_dout, pcm1_dout, pcm2_dout;
  logic               err_timeout, err_overrun, err_clr;

  logic [2:0] cs_vec;
  assign cs_vec = {pcm2_cs, pcm1_cs, pcm_cs};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK96 = ~CLK96;

  ymz_pcm_rom_sequencer #(
    .BANK_AW  (BANK_AW),
    .TIMEOUT  (16),
    .FILL_BYTE(8'h00)
  ) dut (
    .CLK96      (CLK96),
    .RESET96    (RESET96),
    .flush      (flush),
    .ymz_rd     (ymz_rd),
    .ymz_addr   (ymz_addr),
    .ymz_dout   (ymz_dout),
    .ymz_valid  (ymz_valid),
    .ymz_wait   (ymz_wait),
    .pcm_cs     (pcm_cs),
    .pcm1_cs    (pcm1_cs),
    .pcm2_cs    (pcm2_cs),
    .pcm_addr   (pcm_addr),
    .pcm1_addr  (pcm1_addr),
    .pcm2_addr  (pcm2_addr),
    .pcm_ok     (pcm_ok),
    .pcm1_ok    (pcm1_ok),
    .pcm2_ok    (pcm2_ok),
    .pcm_dout   (pcm_dout),
    .pcm1_dout  (pcm1_dout),
    .pcm2_dout  (pcm2_dout),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun),
    .err_clr    (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; afterwards we sit 1 ns past the rising edge.
  task automatic tick();
    @(posedge CLK96);
    #1;
  endtask

  task automatic strobe(input logic [23:0] a);
    ymz_addr = a;
    ymz_rd   = 1'b1;
    tick();
    ymz_rd   = 1'b0;
  endtask

  // Called in a cycle where the bank's CS is high: raise its OK with data d,
  // expect CS to drop, then valid with d one cycle later.
  task automatic complete(input int bank, input logic [7:0] d, input string tag);
    case (bank)
      0: begin pcm_ok  = 1'b1; pcm_dout  = d; end
      1: begin pcm1_ok = 1'b1; pcm1_dout = d; end
      default: begin pcm2_ok = 1'b1; pcm2_dout = d; end
    endcase
    tick();
    pcm_ok = 1'b0; pcm1_ok = 1'b0; pcm2_ok = 1'b0;
    check({tag, "_cs_drop"}, cs_vec, 3'b000);
    check({tag, "_no_early_valid"}, ymz_valid, 1'b0);
    tick();
    check({tag, "_valid"}, ymz_valid, 1'b1);
    check({tag, "_dout"}, ymz_dout, d);
    tick();
    check({tag, "_valid_1cyc"}, ymz_valid, 1'b0);
  endtask

  initial begin
    int   hi;
    logic extra;

    RESET96 = 1'b1; flush = 1'b0; ymz_rd = 1'b0; ymz_addr = '0; err_clr = 1'b0;
    pcm_ok = 1'b0; pcm1_ok = 1'b0; pcm2_ok = 1'b0;
    pcm_dout = '0; pcm1_dout = '0; pcm2_dout = '0;
    tick(); tick();
    check("rst_cs", cs_vec, 3'b000);
    check("rst_addr", {pcm_addr, pcm1_addr, pcm2_addr}, 0);
    check("rst_dout", ymz_dout, 8'h00);
    check("rst_valid", ymz_valid, 1'b0);
    check("rst_wait", ymz_wait, 1'b0);
    check("rst_err", {err_timeout, err_overrun}, 2'b00);
    RESET96 = 1'b0;
    tick();

    // Miss on PCM with OK in the 4th CS cycle.
    ymz_addr = 24'h012345; ymz_rd = 1'b1; #1;
    check("t1_wait_comb", ymz_wait, 1'b1);
    tick(); ymz_rd = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("t1_cs_c%0d", i), cs_vec, 3'b001);
      tick();
    end
    check("t1_cs_c4", cs_vec, 3'b001);
    check("t1_addr", pcm_addr, 22'h012345);
    complete(0, 8'hA5, "t1");

    // Cache hit, then flush forces a miss.
    strobe(24'h012345);
    check("t2_hit_valid", ymz_valid, 1'b1);
    check("t2_hit_dout", ymz_dout, 8'hA5);
    check("t2_hit_cs", cs_vec, 3'b000);
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    strobe(24'h012345);
    check("t2_flush_miss_cs", cs_vec, 3'b001);
    complete(0, 8'hA5, "t2a");
    // Flush in the same cycle as a hitting strobe is a miss.
    flush = 1'b1; strobe(24'h012345); flush = 1'b0;
    check("t2_flush_strobe_cs", cs_vec, 3'b001);
    complete(0, 8'hA5, "t2b");

    // PCM2 miss, out-of-range fill keeps the cache, address wrap cases.
    strobe(24'h812345);
    check("t3_pcm2_cs", cs_vec, 3'b100);
    check("t3_pcm2_addr", pcm2_addr, 22'h012345);
    complete(2, 8'h3C, "t3a");
    strobe(24'hC00000);
    check("t3_oor_valid", ymz_valid, 1'b1);
    check("t3_oor_dout", ymz_dout, 8'h00);
    check("t3_oor_cs", cs_vec, 3'b000);
    tick();
    strobe(24'h812345);
    check("t3_rehit_valid", ymz_valid, 1'b1);
    check("t3_rehit_dout", ymz_dout, 8'h3C);
    check("t3_rehit_cs", cs_vec, 3'b000);
    tick();
    strobe(24'hFFFFFF);
    check("t3_ffffff_fill", {ymz_valid, ymz_dout, cs_vec}, {1'b1, 8'h00, 3'b000});
    tick();
    strobe(24'hBFFFFF);
    check("t3_bfffff_cs", cs_vec, 3'b100);
    check("t3_bfffff_addr", pcm2_addr, 22'h3FFFFF);
    complete(2, 8'h5E, "t3b");

    // Timeout on PCM1.
    strobe(24'h400010);
    check("t4_addr", pcm1_addr, 22'h000010);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      if (cs_vec == 3'b010) hi++;
      tick();
    end
    check("t4_cs_cycles", hi, 16);
    check("t4_cs_drop", cs_vec, 3'b000);
    check("t4_err_timeout", err_timeout, 1'b1);
    check("t4_no_early_valid", ymz_valid, 1'b0);
    tick();
    check("t4_valid", {ymz_valid, ymz_dout}, {1'b1, 8'h00});
    tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("t4_err_clr", err_timeout, 1'b0);

    // Overrun strobe and wrong-bank OKs during REQ.
    strobe(24'h000777);
    check("t5_cs", cs_vec, 3'b001);
    pcm1_ok = 1'b1; pcm2_ok = 1'b1; pcm1_dout = 8'hEE; pcm2_dout = 8'hEE;
    strobe(24'h000888);
    check("t5_overrun", err_overrun, 1'b1);
    check("t5_wrong_ok_cs", cs_vec, 3'b001);
    check("t5_wrong_ok_valid", ymz_valid, 1'b0);
    tick();
    check("t5_still_cs", cs_vec, 3'b001);
    pcm1_ok = 1'b0; pcm2_ok = 1'b0;
    complete(0, 8'h77, "t5");
    extra = 1'b0;
    for (int i = 0; i < 4; i++) begin
      extra = extra | ymz_valid | (|cs_vec);
      tick();
    end
    check("t5_no_extra", extra, 1'b0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("t5_overrun_clr", err_overrun, 1'b0);

    // Flush during REQ: byte returned but not cached.
    strobe(24'h000555);
    check("t6_cs", cs_vec, 3'b001);
    flush = 1'b1; tick(); flush = 1'b0;
    complete(0, 8'h55, "t6a");
    strobe(24'h000555);
    check("t6_not_cached", cs_vec, 3'b001);
    complete(0, 8'h55, "t6b");
    strobe(24'h000555);
    check("t6_cached", {ymz_valid, ymz_dout, cs_vec}, {1'b1, 8'h55, 3'b000});
    tick();

    // Reset mid-request.
    strobe(24'h000999);
    check("t7_cs", cs_vec, 3'b001);
    #2 RESET96 = 1'b1;
    #1;
    check("t7_async_cs", cs_vec, 3'b000);
    check("t7_rst_wait", ymz_wait, 1'b0);
    @(posedge CLK96); #1 RESET96 = 1'b0;
    extra = 1'b0;
    for (int i = 0; i < 3; i++) begin
      extra = extra | ymz_valid;
      tick();
    end
    check("t7_no_valid", extra, 1'b0);
    check("t7_dout_rst", ymz_dout, 8'h00);
    strobe(24'h000555);
    check("t7_cache_inval", cs_vec, 3'b001);
    complete(0, 8'h55, "t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
